// File: rtl/rr_index_sequencer.sv
// Round-robin index sequencer feeding a 3-to-8 one-hot decoder.
// Scans 8 request lines from a rotating priority pointer and holds the chosen
// index for a minimum dwell and until acknowledged. A single IDLE cycle always
// separates consecutive grants so the decoder output passes through a clean gap.
module rr_index_sequencer #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [7:0]       req,
  input  logic             grant_ack,
  output logic [2:0]       grant_idx,
  output logic             grant_valid,
  output logic             busy,
  output logic [CNT_W-1:0] grant_cnt
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [7:0]       DWELL_MAX = 8'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [2:0]       grant_idx_q, grant_idx_d;
  logic             grant_valid_q, grant_valid_d;
  logic             busy_q;
  logic [CNT_W-1:0] grant_cnt_q, grant_cnt_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [7:0]       dwell_q, dwell_d;
  logic             ack_seen_q, ack_seen_d;

  logic             release_rdy_s;
  logic             abandon_s;

  // First set request bit at or after p, wrapping 7->0; iterating downward lets
  // the lowest offset (highest priority) win.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] pick;
    logic [2:0] cand;
    pick = p;
    for (int i = 7; i >= 0; i--) begin
      cand = p + 3'(i);
      pick = r[cand] ? cand : pick;
    end
    return pick;
  endfunction

  // Release / abandon qualifiers for the grant in progress.
  always_comb begin
    release_rdy_s = (grant_ack | ack_seen_q) && (dwell_q == DWELL_MAX);
    abandon_s     = ~req[grant_idx_q];
  end

  // Next-state and next-output logic for the two-state sequencer.
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    grant_cnt_d   = grant_cnt_q;
    ptr_d         = ptr_q;
    dwell_d       = dwell_q;
    ack_seen_d    = ack_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (enable && (req != 8'h00)) begin
          state_d       = ST_GRANT;
          grant_idx_d   = rr_pick(req, ptr_q);
          grant_valid_d = 1'b1;
          dwell_d       = 8'd0;
          ack_seen_d    = 1'b0;
        end else begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
        end
      end
      ST_GRANT: begin
        if (release_rdy_s) begin
          // Release wins over a simultaneous abandon, so it is counted.
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          grant_cnt_d   = grant_cnt_q + CNT_ONE;
          ptr_d         = grant_idx_q + 3'd1;
        end else if (abandon_s) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          ptr_d         = grant_idx_q + 3'd1;
        end else begin
          dwell_d       = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + 8'd1;
          ack_seen_d    = ack_seen_q | grant_ack;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= 3'd0;
      grant_valid_q <= 1'b0;
      busy_q        <= 1'b0;
      grant_cnt_q   <= {CNT_W{1'b0}};
      ptr_q         <= 3'd0;
      dwell_q       <= 8'd0;
      ack_seen_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      busy_q        <= grant_valid_d;
      grant_cnt_q   <= grant_cnt_d;
      ptr_q         <= ptr_d;
      dwell_q       <= dwell_d;
      ack_seen_q    <= ack_seen_d;
    end
  end

  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign busy        = busy_q;
  assign grant_cnt   = grant_cnt_q;

endmodule

// File: tb/tb_rr_index_sequencer.sv
// Directed bench for rr_index_sequencer. Expected grants (index, valid length,
// count after the grant ends) are queued as stimulus is applied; a monitor pops
// and compares each one when grant_valid falls.
module tb_rr_index_sequencer;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [7:0]  req;
  logic        grant_ack;
  logic [2:0]  grant_idx;
  logic        grant_valid;
  logic        busy;
  logic [15:0] grant_cnt;
  logic [2:0]  w4_idx;
  logic        w4_valid;
  logic        w4_busy;
  logic [3:0]  w4_cnt;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [2:0]  idx;
    int          len;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  rr_index_sequencer #(.HOLD_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .grant_ack(grant_ack),
    .grant_idx(grant_idx), .grant_valid(grant_valid), .busy(busy), .grant_cnt(grant_cnt)
  );

  rr_index_sequencer #(.HOLD_CYCLES(4), .CNT_W(4)) dut_w4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .req(req), .grant_ack(grant_ack),
    .grant_idx(w4_idx), .grant_valid(w4_valid), .busy(w4_busy), .grant_cnt(w4_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] idx, input int len, input logic [15:0] cnt);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.cnt = cnt;
    sb_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_high(input string tag, input int budget);
    int cyc = 0;
    while (grant_valid !== 1'b1 && cyc < budget) begin
      step(1);
      cyc++;
    end
    check(tag, {31'd0, grant_valid}, 32'd1);
  endtask

  task automatic wait_falls(input string tag, input int n, input int budget);
    int   seen = 0;
    int   cyc  = 0;
    logic prev;
    prev = grant_valid;
    while (seen < n && cyc < budget) begin
      step(1);
      cyc++;
      if (prev === 1'b1 && grant_valid === 1'b0) seen++;
      prev = grant_valid;
    end
    check(tag, seen, n);
  endtask

  // Monitor: measures each grant and compares it against the scoreboard.
  initial begin
    logic       prev_valid;
    int         mon_len;
    logic [2:0] mon_idx;
    exp_t       e;
    prev_valid = 1'b0;
    mon_len    = 0;
    mon_idx    = 3'd0;
    forever begin
      @(negedge clk);
      check("busy_eq_valid", {31'd0, busy}, {31'd0, grant_valid});
      check("cnt_w4_tracks", {28'd0, w4_cnt}, {28'd0, grant_cnt[3:0]});
      if (grant_valid === 1'b1 && prev_valid !== 1'b1) begin
        mon_len = 1;
        mon_idx = grant_idx;
      end else if (grant_valid === 1'b1) begin
        mon_len++;
        check("idx_stable", {29'd0, grant_idx}, {29'd0, mon_idx});
      end else if (prev_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL unexpected_grant: observed idx %0d len %0d, expected none", mon_idx, mon_len);
        end else begin
          e = sb_q.pop_front();
          check("sb_idx", {29'd0, mon_idx}, {29'd0, e.idx});
          check("sb_len", mon_len, e.len);
          check("sb_cnt", {16'd0, grant_cnt}, {16'd0, e.cnt});
        end
      end
      prev_valid = grant_valid;
    end
  end

  initial begin
    // 1: reset with all requests pending; first grant to idx 0.
    rst_n = 1'b0; enable = 1'b1; req = 8'hFF; grant_ack = 1'b0;
    step(2);
    check("rst_valid", {31'd0, grant_valid}, 32'd0);
    check("rst_busy",  {31'd0, busy},        32'd0);
    check("rst_idx",   {29'd0, grant_idx},   32'd0);
    check("rst_cnt",   {16'd0, grant_cnt},   32'd0);
    push(3'd0, 4, 16'd1);
    rst_n = 1'b1;
    step(1);
    check("first_valid", {31'd0, grant_valid}, 32'd1);
    check("first_idx",   {29'd0, grant_idx},   32'd0);
    grant_ack = 1'b1;
    wait_falls("t1_release", 1, 20);
    req = 8'h00; grant_ack = 1'b0;
    check("t1_cnt", {16'd0, grant_cnt}, 32'd1);
    step(2);

    // 2: two channels alternate with ack held.
    rst_n = 1'b0;
    step(1);
    check("t2_rst_cnt", {16'd0, grant_cnt}, 32'd0);
    rst_n = 1'b1;
    push(3'd2, 4, 16'd1); push(3'd5, 4, 16'd2);
    push(3'd2, 4, 16'd3); push(3'd5, 4, 16'd4);
    req = 8'b0010_0100; grant_ack = 1'b1;
    wait_falls("t2_four_grants", 4, 60);
    req = 8'h00; grant_ack = 1'b0;
    check("t2_cnt", {16'd0, grant_cnt}, 32'd4);
    step(2);

    // 3: single early ack pulse is remembered.
    push(3'd6, 4, 16'd5);
    req = 8'h40;
    wait_high("t3_rise", 10);
    grant_ack = 1'b1;
    step(1);
    grant_ack = 1'b0;
    wait_falls("t3_release", 1, 20);
    req = 8'h00;
    check("t3_cnt", {16'd0, grant_cnt}, 32'd5);
    step(2);

    // 4: request dropped in the second grant cycle, then idx 4 follows.
    push(3'd3, 2, 16'd5);
    push(3'd4, 4, 16'd6);
    req = 8'h18;
    wait_high("t4_rise", 10);
    step(1);
    req = 8'h10;
    wait_falls("t4_abandon", 1, 10);
    check("t4_abandon_cnt", {16'd0, grant_cnt}, 32'd5);
    grant_ack = 1'b1;
    wait_falls("t4_next", 1, 20);
    req = 8'h00; grant_ack = 1'b0;
    check("t4_cnt", {16'd0, grant_cnt}, 32'd6);
    step(2);

    // 5: pointer wraps 7 -> 0; enable dropped mid-grant stops further grants.
    push(3'd7, 4, 16'd7);
    push(3'd0, 4, 16'd8);
    req = 8'h81; grant_ack = 1'b1;
    wait_falls("t5_idx7", 1, 20);
    wait_high("t5_rise0", 10);
    enable = 1'b0;
    wait_falls("t5_idx0", 1, 20);
    step(10);
    check("t5_no_grant", {31'd0, grant_valid}, 32'd0);
    check("t5_idx_held", {29'd0, grant_idx},   32'd0);
    check("t5_cnt",      {16'd0, grant_cnt},   32'd8);
    req = 8'h00; grant_ack = 1'b0; enable = 1'b1;
    step(2);

    // 6: 4-bit counter wraps after 16 grants; reset in mid-grant.
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      push(3'(i % 8), 4, 16'(i + 1));
    end
    req = 8'hFF; grant_ack = 1'b1;
    wait_falls("t6_fifteen", 15, 200);
    check("t6_w4_15", {28'd0, w4_cnt}, 32'd15);
    wait_falls("t6_sixteen", 1, 20);
    check("t6_w4_wrap", {28'd0, w4_cnt},    32'd0);
    check("t6_cnt16",   {16'd0, grant_cnt}, 32'd16);
    push(3'd0, 2, 16'd0);
    wait_high("t6_rise", 10);
    step(1);
    rst_n = 1'b0; req = 8'h00; grant_ack = 1'b0;
    step(1);
    check("t6_rst_valid", {31'd0, grant_valid}, 32'd0);
    check("t6_rst_cnt",   {16'd0, grant_cnt},   32'd0);
    check("t6_rst_w4cnt", {28'd0, w4_cnt},      32'd0);
    rst_n = 1'b1;
    step(3);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
